// File: rtl/axi_async_chan_rx.sv
// axi_async_chan_rx
// Receive side of one channel of a token-based asynchronous AXI link.
// The remote domain writes a slot of async_data_i and then toggles the
// matching bit of async_writetoken_i. This side synchronizes the tokens,
// treats a slot as full while its synced token differs from the local read
// pointer bit, and moves slots in order into a single output register. It
// toggles the read pointer bit to hand the slot back to the writer.
//
// Ports
//   clk_i               local clock
//   rst_ni              synchronous active-low reset
//   async_data_i        slot array, slot k = [k*DATA_WIDTH +: DATA_WIDTH]
//   async_writetoken_i  remote per-slot write tokens (toggle = slot written)
//   async_readpointer_o local per-slot read tokens (toggle = slot consumed)
//   data_o / valid_o    output beat, held stable while stalled
//   ready_i             consumer accepts the beat
//   occupancy_o         slots seen full locally, output register excluded
module axi_async_chan_rx #(
    parameter int DATA_WIDTH   = 64,
    parameter int BUFFER_WIDTH = 8,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [BUFFER_WIDTH*DATA_WIDTH-1:0] async_data_i,
    input  logic [BUFFER_WIDTH-1:0]            async_writetoken_i,
    output logic [BUFFER_WIDTH-1:0]            async_readpointer_o,
    output logic [DATA_WIDTH-1:0]              data_o,
    output logic                               valid_o,
    input  logic                               ready_i,
    output logic [$clog2(BUFFER_WIDTH+1)-1:0]  occupancy_o
);
    localparam int IDX_W = $clog2(BUFFER_WIDTH);
    localparam int OCC_W = $clog2(BUFFER_WIDTH+1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BUFFER_WIDTH-1);

    // wt_pipe[0] is the first capture stage, wt_pipe[SYNC_STAGES-1] the last
    logic [SYNC_STAGES-1:0][BUFFER_WIDTH-1:0] wt_pipe;
    logic [BUFFER_WIDTH-1:0] wt_sync;
    logic [BUFFER_WIDTH-1:0] rp;
    logic [BUFFER_WIDTH-1:0] slot_full;
    logic [IDX_W-1:0]        rd_idx;
    logic [DATA_WIDTH-1:0]   slot_data [BUFFER_WIDTH];
    logic                    load;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wt_pipe <= '0;
        end else begin
            wt_pipe <= {wt_pipe[SYNC_STAGES-2:0], async_writetoken_i};
        end
    end

    assign wt_sync   = wt_pipe[SYNC_STAGES-1];
    assign slot_full = wt_sync ^ rp;

    for (genvar k = 0; k < BUFFER_WIDTH; k++) begin : g_slot
        assign slot_data[k] = async_data_i[k*DATA_WIDTH +: DATA_WIDTH];
    end

    // Slot data is only sampled on the load edge; the writer keeps it
    // stable from its token toggle until our rp toggle reaches it.
    assign load = slot_full[rd_idx] && (!valid_o || ready_i);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rp      <= '0;
            rd_idx  <= '0;
            valid_o <= 1'b0;
            data_o  <= '0;
        end else if (load) begin
            data_o  <= slot_data[rd_idx];
            valid_o <= 1'b1;
            rp      <= rp ^ (BUFFER_WIDTH'(1) << rd_idx);
            // explicit wrap so non power-of-two depths work
            rd_idx  <= (rd_idx == LAST_IDX) ? '0 : rd_idx + IDX_W'(1);
        end else if (ready_i && valid_o) begin
            valid_o <= 1'b0;
        end
    end

    assign async_readpointer_o = rp;

    always_comb begin
        occupancy_o = '0;
        for (int k = 0; k < BUFFER_WIDTH; k++) begin
            occupancy_o = occupancy_o + OCC_W'(slot_full[k]);
        end
    end

endmodule

// File: doc/axi_async_chan_rx.md
# axi_async_chan_rx

Receiving end of one channel of the token-based asynchronous AXI link. It reads payload from the slot buffer written by the remote clock domain and synchronizes that domain's per-slot write tokens. It acknowledges consumed slots by toggling per-slot read-pointer bits, and presents the data as a local valid/ready stream. One instance sits on each channel where the local side receives: AW, W and AR on the slave side, B and R on the master side.

## Interface
- DATA_WIDTH, 64: payload bits per slot (packed channel fields, e.g. id/addr/len/... for AW).
- BUFFER_WIDTH, 8: number of slots; equals the token and pointer width; any value ≥ 2, not necessarily a power of two.
- SYNC_STAGES, 2: flip-flop stages on each write-token bit; ≥ 2.
- clk_i  in  1  local clock.
- rst_ni  in  1  synchronous, active-low reset.
- async_data_i  in  BUFFER_WIDTH*DATA_WIDTH  slot array from the remote domain; slot k = bits [k*DATA_WIDTH +: DATA_WIDTH].
- async_writetoken_i  in  BUFFER_WIDTH  remote token; bit k toggles after slot k is written.
- async_readpointer_o  out  BUFFER_WIDTH  local token; bit k toggles when slot k is consumed.
- data_o  out  DATA_WIDTH  payload of the current beat.
- valid_o  out  1  beat available.
- ready_i  in  1  local consumer accepts the beat.
- occupancy_o  out  $clog2(BUFFER_WIDTH+1)  number of slots seen full locally, excluding the output register.

## Operation
- Sync: wt_sync = async_writetoken_i passed through SYNC_STAGES registers per bit. No other async input is registered before use.
- Slot k is full when wt_sync[k] != rp[k], where rp is the register driving async_readpointer_o.
- rd_idx: in-order read index, 0..BUFFER_WIDTH-1. It wraps from BUFFER_WIDTH-1 to 0 with explicit compare, not modulo power of two.
- Output stage: a single register holding data_o and valid_o.
  - load = slot rd_idx full AND (!valid_o OR ready_i).
  - On load: data_o <= slot rd_idx of async_data_i; valid_o <= 1; rp[rd_idx] toggles; rd_idx advances.
  - If ready_i && valid_o && !load: valid_o <= 0, data_o holds its value.
- The remote writer guarantees slot data is stable before its token toggles and until the matching rp bit toggles back through its synchronizer. The rx reads a slot's data only on the cycle of load.
- occupancy_o = popcount(wt_sync ^ rp), combinational from registers.
- Reset (rst_ni low at posedge):
  - rp, rd_idx, all sync stages, valid_o and data_o go to 0.
  - async_readpointer_o = 0, occupancy_o = 0.
  - Reset mid-operation discards the output beat and all pending slots. The remote end must be reset in the same window; the rx does not handle a one-sided reset.
- Stream rule: while valid_o && !ready_i, data_o and valid_o are stable.

## Timing
- Latency: the token toggle captured at edge 0 becomes visible in wt_sync after edge SYNC_STAGES-1. load happens on edge SYNC_STAGES, so valid_o is high after SYNC_STAGES edges (2 with defaults), if the output register is free.
- Throughput: one beat per cycle while slots are full and ready_i is held high.
- rp[k] toggles on the same edge that sets valid_o for slot k. The freed slot is therefore visible remotely SYNC_STAGES remote cycles later.
- A slot consumed locally is never re-read: its full condition drops on the load edge because rp is local.
- Simultaneous events:
  - Handshake and load in the same cycle: the new beat replaces the old one, valid_o stays 1, and there is no bubble.
  - A token toggle arriving for a slot other than rd_idx is only counted in occupancy_o.
- All buffer slots full: occupancy_o = BUFFER_WIDTH. No special handling is needed, since the remote writer stalls.

## Test plan
- Reset: hold rst_ni low for 3 cycles with random tokens -> async_readpointer_o=0, valid_o=0, data_o=0, occupancy_o=0. Release -> outputs stay 0 until wt_sync differs.
- Single beat: write slot0=0xDEAD_BEEF and toggle wt[0] -> valid_o=1 exactly 2 edges later with data_o=0xDEAD_BEEF, rp[0]=1. With ready_i=1 -> valid_o=0 next cycle.
- Burst: fill all 8 slots with 0..7, ready_i=1 -> 8 consecutive beats 0..7 with no bubble, rd_idx wraps to 0, rp=0xFF.
- Backpressure: fill 3 slots, ready_i=0 -> valid_o=1, data_o=slot0 value stable, occupancy_o=2. Raise ready_i -> remaining beats in order.
- Wrap with odd depth: BUFFER_WIDTH=5, stream 12 beats -> indices 0,1,2,3,4,0,1,... and data in order, rp toggled per consumption.
- Mid-stream reset: reset after 3 of 6 beats -> outputs return to reset values within one edge. No beat is emitted until new token toggles arrive after reset.
